// File: rtl/limsw_pkg.sv
// Shared constants for the limit-switch / alarm-input controller:
// register offsets, channel ceiling, SOFT register bit positions.
package limsw_pkg;

    localparam int MAX_CH = 16;

    localparam logic [15:0] OFF_KEY         = 16'h00;
    localparam logic [15:0] OFF_LEVEL       = 16'h02;
    localparam logic [15:0] OFF_FLAG        = 16'h04;
    localparam logic [15:0] OFF_MASK        = 16'h06;
    localparam logic [15:0] OFF_EDGE        = 16'h08;
    localparam logic [15:0] OFF_IRQ_FLAG_EN = 16'h0A;
    localparam logic [15:0] OFF_IRQ_EDGE_EN = 16'h0C;
    localparam logic [15:0] OFF_TIMEOUT     = 16'h0E;
    localparam logic [15:0] OFF_SOFT        = 16'h10;

    // SOFT write bits
    localparam int SOFT_SET_BIT = 0;
    localparam int SOFT_CLR_BIT = 1;

    // Expand the two byte enables to a 16-bit bit mask
    function automatic logic [15:0] be_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/limsw_if.sv
// 16-bit register bus: separate read/write addresses, byte enables,
// single-cycle write strobe, registered read data.
interface limsw_if;
    logic [15:0] rdaddr;
    logic [15:0] wraddr;
    logic [1:0]  be;
    logic        write;
    logic [15:0] wrdata;
    logic [15:0] rddata;

    modport master (
        output rdaddr, wraddr, be, write, wrdata,
        input  rddata
    );

    modport slave (
        input  rdaddr, wraddr, be, write, wrdata,
        output rddata
    );
endinterface

// File: rtl/limsw_ctrl_debounce.sv
// One input channel: 2-FF synchroniser, polarity, sampled history filter,
// unstable-sample counter. Ports: clk/sclr, clr_i, tick_i, sig_i, pol_i -> out/ready/timeout.
module input_debounce #(
    parameter int FILTER_WIDTH    = 8,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic clk,
    input  logic sclr,
    input  logic clr_i,
    input  logic tick_i,
    input  logic sig_i,
    input  logic pol_i,
    output logic out_o,
    output logic ready_o,
    output logic timeout_o
);
    localparam int UW = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int RW = $clog2(FILTER_WIDTH);

    logic [1:0]              sync_q;
    logic [FILTER_WIDTH-1:0] hist_q, hist_d;
    logic                    out_q, out_d;
    logic                    ready_q, ready_d;
    logic                    tmo_q, tmo_d;
    logic [RW-1:0]           rcnt_q, rcnt_d;
    logic [UW-1:0]           unst_q, unst_d;

    always_comb begin
        hist_d  = hist_q;
        out_d   = out_q;
        ready_d = ready_q;
        tmo_d   = tmo_q;
        rcnt_d  = rcnt_q;
        unst_d  = unst_q;
        if (tick_i) begin
            hist_d = {hist_q[FILTER_WIDTH-2:0], sync_q[1] ^ pol_i};
            if ((&hist_d) || (~|hist_d)) begin
                out_d  = hist_d[0];
                unst_d = '0;
                tmo_d  = 1'b0;
            end else begin
                if (unst_q != UW'(TIMEOUT_SAMPLES))
                    unst_d = unst_q + 1'b1;
                if (unst_d == UW'(TIMEOUT_SAMPLES))
                    tmo_d = 1'b1;
            end
            if (!ready_q) begin
                if (rcnt_q == RW'(FILTER_WIDTH - 1))
                    ready_d = 1'b1;
                else
                    rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], sig_i};
    end

    // clr_i (LEVEL change) restarts the filter like a reset
    always_ff @(posedge clk) begin
        if (sclr || clr_i) begin
            hist_q  <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b0;
            tmo_q   <= 1'b0;
            rcnt_q  <= '0;
            unst_q  <= '0;
        end else begin
            hist_q  <= hist_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            tmo_q   <= tmo_d;
            rcnt_q  <= rcnt_d;
            unst_q  <= unst_d;
        end
    end

    assign out_o     = out_q;
    assign ready_o   = ready_q;
    assign timeout_o = tmo_q;
endmodule

// File: rtl/limsw_ctrl.sv
// Limit-switch / alarm controller: per-channel debounce, flags, edges, irq, lock.
// Ports: clk, sclr, bus (limsw_if.slave), sig_in -> key, alarm, alarm_clk, lock, nirq.
module limsw_ctrl
    import limsw_pkg::*;
#(
    parameter logic [15:0]   BAR             = 16'h40,
    parameter logic [15:0]   MASK            = 16'h1F,
    parameter int            N_CH            = 10,
    parameter int            POLL_DIV        = 250,
    parameter int            FILTER_WIDTH    = 8,
    parameter int            TIMEOUT_SAMPLES = 1024,
    parameter logic [N_CH-1:0] LOCK_MASK     = {N_CH{1'b1}}
) (
    input  logic            clk,
    input  logic            sclr,
    limsw_if.slave          bus,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] key,
    output logic            alarm,
    output logic            alarm_clk,
    output logic            lock,
    output logic            nirq
);
    localparam int PW = $clog2(POLL_DIV);

    logic [PW-1:0]   poll_q, poll_d;
    logic            tick;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] ifen_q, ifen_d;
    logic [N_CH-1:0] ieen_q, ieen_d;
    logic [N_CH-1:0] flag_q, flag_d;
    logic [N_CH-1:0] edge_q, edge_d;
    logic [N_CH-1:0] keyr_q, keyr_d;
    logic            soft_q, soft_d;
    logic            sset_q, sset_d;
    logic            adly_q, adly_d;
    logic            newlv_q, newlv_d;
    logic            lock_q, lock_d;
    logic            nirq_q, nirq_d;
    logic [15:0]     rd_q, rd_d;

    logic [N_CH-1:0] db_out, db_rdy, db_tmo;
    logic            all_ready, force_clr;
    logic            wr_hit, rd_hit;
    logic [15:0]     wr_off, rd_off;
    logic [N_CH-1:0] wm, wd, flag_clr, edge_clr;
    logic            we_level, we_mask, we_flag, we_edge;
    logic            we_ifen, we_ieen, we_soft;

    // Shared poll tick
    assign tick   = (poll_q == PW'(POLL_DIV - 1));
    assign poll_d = tick ? '0 : poll_q + 1'b1;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_debounce #(
            .FILTER_WIDTH   (FILTER_WIDTH),
            .TIMEOUT_SAMPLES(TIMEOUT_SAMPLES)
        ) u_db (
            .clk      (clk),
            .sclr     (sclr),
            .clr_i    (newlv_q),
            .tick_i   (tick),
            .sig_i    (sig_in[i]),
            .pol_i    (level_q[i]),
            .out_o    (db_out[i]),
            .ready_o  (db_rdy[i]),
            .timeout_o(db_tmo[i])
        );
    end

    // Fail-safe: unknown or unstable inputs read as active
    assign key       = db_out | ~db_rdy | db_tmo;
    assign all_ready = &db_rdy;
    assign force_clr = newlv_q | ~all_ready;

    // Write decode
    assign wr_hit   = bus.write && ((bus.wraddr & ~MASK) == BAR);
    assign wr_off   = bus.wraddr & MASK;
    assign wm       = N_CH'(be_mask(bus.be));
    assign wd       = N_CH'(bus.wrdata);
    assign we_level = wr_hit && (wr_off == OFF_LEVEL);
    assign we_mask  = wr_hit && (wr_off == OFF_MASK);
    assign we_flag  = wr_hit && (wr_off == OFF_FLAG);
    assign we_edge  = wr_hit && (wr_off == OFF_EDGE);
    assign we_ifen  = wr_hit && (wr_off == OFF_IRQ_FLAG_EN);
    assign we_ieen  = wr_hit && (wr_off == OFF_IRQ_EDGE_EN);
    assign we_soft  = wr_hit && (wr_off == OFF_SOFT) && bus.be[0];

    assign flag_clr = we_flag ? (wd & wm) : '0;
    assign edge_clr = we_edge ? (wd & wm) : '0;

    always_comb begin
        level_d = we_level ? ((level_q & ~wm) | (wd & wm)) : level_q;
        mask_d  = we_mask  ? ((mask_q  & ~wm) | (wd & wm)) : mask_q;
        ifen_d  = we_ifen  ? ((ifen_q  & ~wm) | (wd & wm)) : ifen_q;
        ieen_d  = we_ieen  ? ((ieen_q  & ~wm) | (wd & wm)) : ieen_q;
        newlv_d = we_level && (|bus.be);

        // Set beats W1C in the same cycle
        flag_d = force_clr ? '0
               : mask_q & (key | (flag_q & ~flag_clr));
        edge_d = force_clr ? '0
               : (~keyr_q & key) | (edge_q & ~edge_clr);
        keyr_d = newlv_q ? '1 : key;

        sset_d = we_soft && bus.wrdata[SOFT_SET_BIT];
        if (sset_d)
            soft_d = 1'b1;
        else if (we_soft && bus.wrdata[SOFT_CLR_BIT])
            soft_d = 1'b0;
        else
            soft_d = soft_q;

        adly_d = newlv_q ? 1'b0 : alarm;
        lock_d = force_clr ? 1'b1
               : (|(key & mask_q & LOCK_MASK)) | soft_q;
        nirq_d = newlv_q ? 1'b1
               : ~|((flag_q & ifen_q) | (edge_q & ieen_q));
    end

    // Read mux
    assign rd_hit = (bus.rdaddr & ~MASK) == BAR;
    assign rd_off = bus.rdaddr & MASK;

    always_comb begin
        rd_d = '0;
        if (rd_hit) begin
            unique case (rd_off)
                OFF_KEY:         rd_d = 16'(key);
                OFF_LEVEL:       rd_d = 16'(level_q);
                OFF_FLAG:        rd_d = 16'(flag_q);
                OFF_MASK:        rd_d = 16'(mask_q);
                OFF_EDGE:        rd_d = 16'(edge_q);
                OFF_IRQ_FLAG_EN: rd_d = 16'(ifen_q);
                OFF_IRQ_EDGE_EN: rd_d = 16'(ieen_q);
                OFF_TIMEOUT:     rd_d = 16'(db_tmo);
                OFF_SOFT:        rd_d = {14'h0, soft_q, alarm};
                default:         rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            poll_q  <= '0;
            level_q <= '0;
            mask_q  <= '1;
            ifen_q  <= '0;
            ieen_q  <= '0;
            flag_q  <= '0;
            edge_q  <= '0;
            keyr_q  <= '1;
            soft_q  <= 1'b0;
            sset_q  <= 1'b0;
            adly_q  <= 1'b0;
            newlv_q <= 1'b0;
            lock_q  <= 1'b1;
            nirq_q  <= 1'b1;
            rd_q    <= '0;
        end else begin
            poll_q  <= poll_d;
            level_q <= level_d;
            mask_q  <= mask_d;
            ifen_q  <= ifen_d;
            ieen_q  <= ieen_d;
            flag_q  <= flag_d;
            edge_q  <= edge_d;
            keyr_q  <= keyr_d;
            soft_q  <= soft_d;
            sset_q  <= sset_d;
            adly_q  <= adly_d;
            newlv_q <= newlv_d;
            lock_q  <= lock_d;
            nirq_q  <= nirq_d;
            rd_q    <= rd_d;
        end
    end

    assign alarm      = (|flag_q) | soft_q;
    assign alarm_clk  = (alarm & ~adly_q) | sset_q;
    assign lock       = lock_q;
    assign nirq       = nirq_q;
    assign bus.rddata = rd_q;
endmodule
